// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns a 4:1 bit mux. One requester holds the mux
// at a time, for at most HOLD_MAX cycles. Each release is followed by a
// one-cycle turnaround, and the next grant starts at the index after the
// previous owner.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] req_in,
  input  logic [3:0] data_in,
  output logic [3:0] grant_out,
  output logic [1:0] sel_out,
  output logic       busy_out,
  output logic       y_out
);

  localparam int             CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_grant, w_grant_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic          r_busy, w_busy_nxt;

  logic          w_any;
  logic [1:0]    w_win;
  logic [1:0]    w_idx;
  logic          w_release;

  // Rotating priority scan. Iterating from lowest to highest priority lets
  // the last hit be the winner, so no separate "found" flag is needed.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req_in[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Owner drop and timeout can coincide; both map to a single release.
  assign w_release = ~req_in[r_sel] | (r_cnt == CNT_LAST);

  // Next-state and next-output logic. Every value defaults to holding.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    case (r_state)
      GRANT: begin
        if (w_release) begin
          // The owner goes to the back of the line. sel_out keeps the last owner.
          w_state_nxt = TURN;
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_sel + 2'd1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        // IDLE and TURN both arbitrate. TURN already uses the advanced pointer.
        if (w_any) begin
          w_state_nxt = GRANT;
          w_grant_nxt = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
        end
      end
    endcase
  end

  // State and output registers, with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign grant_out = r_grant;
  assign sel_out   = r_sel;
  assign busy_out  = r_busy;
  assign y_out     = r_busy & data_in[r_sel];

endmodule
